// File: rtl/lsu_mem_ctrl.sv
// RV32I MEM-stage load/store unit: one req/gnt/rvalid data-bus transaction per access,
// byte-lane steering for stores, lane extraction and sign/zero extension for loads.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [2:0]  Load_type,
  input  logic [1:0]  Store_type,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Access size code: 2 = word, 1 = half, 0 = byte. Unused encodings fall back to word.
  function automatic logic [1:0] size_of(input logic is_st, input logic [1:0] st,
                                         input logic [2:0] lt);
    logic [1:0] sz;
    sz = 2'd2;
    if (is_st) begin
      case (st)
        2'b01:   sz = 2'd1;
        2'b10:   sz = 2'd0;
        default: sz = 2'd2;
      endcase
    end else begin
      case (lt)
        3'b001, 3'b011: sz = 2'd1;
        3'b010, 3'b111: sz = 2'd0;
        default:        sz = 2'd2;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] ofs);
    return (sz == 2'd2) ? (ofs == 2'b00) : (sz == 2'd1) ? !ofs[0] : 1'b1;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ofs);
    return (sz == 2'd2) ? 4'b1111 : (sz == 2'd1) ? (4'b0011 << ofs) : (4'b0001 << ofs);
  endfunction

  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] sd);
    return (sz == 2'd2) ? sd : (sz == 2'd1) ? {2{sd[15:0]}} : {4{sd[7:0]}};
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] lt, input logic [1:0] ofs,
                                          input logic [31:0] rd);
    logic [31:0] lane;
    logic [31:0] res;
    lane = rd >> {ofs, 3'b000};
    case (lt)
      3'b001:  res = {{16{lane[15]}}, lane[15:0]};
      3'b010:  res = {{24{lane[7]}}, lane[7:0]};
      3'b011:  res = {16'h0000, lane[15:0]};
      3'b111:  res = {24'h000000, lane[7:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_p0;
  logic              we_p0;
  logic [2:0]        lt_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;
  logic              err_p0;

  logic              op, latch, capture, abort, timeout;
  logic [1:0]        cur_size;

  assign op       = op_valid & (mem_read | mem_write);
  assign cur_size = size_of(mem_write, Store_type, Load_type);
  assign timeout  = (cnt == CNT_LAST);

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    mem_req    = 1'b0;
    latch      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (op && !rst) begin
          if (is_aligned(cur_size, addr[1:0])) begin
            stall     = 1'b1;
            latch     = 1'b1;
            state_nxt = S_REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_gnt) begin
          if (we_p0) begin
            state_nxt = S_DONE;
          end else if (mem_rvalid) begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: begin
        done      = 1'b1;
        bus_err   = err_p0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus fields come only from the latched op, and read as zero whenever no request is out.
  assign mem_we    = mem_req & we_p0;
  assign mem_addr  = mem_req ? {addr_p0[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_p0 : 4'h0;
  assign mem_wdata = mem_req ? wdata_p0 : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_p0   <= 32'h0;
      we_p0     <= 1'b0;
      lt_p0     <= 3'b000;
      be_p0     <= 4'h0;
      wdata_p0  <= 32'h0;
      err_p0    <= 1'b0;
      load_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        addr_p0  <= addr;
        we_p0    <= mem_write;
        lt_p0    <= Load_type;
        be_p0    <= mem_write ? byte_en(cur_size, addr[1:0]) : 4'b1111;
        wdata_p0 <= mem_write ? lanes(cur_size, store_data) : 32'h0;
        err_p0   <= 1'b0;
        cnt      <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (capture)
        load_data <= extract(lt_p0, addr_p0[1:0], mem_rdata);
      // A timed-out load still reports a defined (zero) result alongside bus_err.
      if (abort) begin
        err_p0 <= 1'b1;
        if (!we_p0)
          load_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a bus responder with programmable gnt/rvalid latency
// drives each access to completion and the observed bus and pipeline outputs are compared.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, mem_read, mem_write;
  logic [31:0] addr, store_data;
  logic [2:0]  Load_type;
  logic [1:0]  Store_type;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  int          r_stall, r_req, r_wait, r_mis;
  logic        r_done, r_err;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .store_data(store_data), .Load_type(Load_type), .Store_type(Store_type),
    .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Holds one op on the pipeline side until done (or a misaligned reject) and plays the bus:
  // gnt after gnt_wait refused REQ cycles, rvalid rv_lag cycles after gnt (0 = same cycle).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] sd, input logic [2:0] lt, input logic [1:0] st,
                           input int gnt_wait, input int rv_lag, input logic [31:0] rdat);
    logic given;
    int   since;
    logic fin;
    given = 1'b0; since = 0; fin = 1'b0;
    r_stall = 0; r_req = 0; r_wait = 0; r_mis = 0; r_done = 1'b0; r_err = 1'b0;
    r_ld = 32'h0; r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0; r_we = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      op_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; store_data = sd;
      Load_type = lt; Store_type = st; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rdat;
      #1;
      if (mem_req && !given) begin
        if (r_req == 0) begin
          r_addr = mem_addr; r_wdata = mem_wdata; r_be = mem_be; r_we = mem_we;
        end
        r_req++;
        if (r_req > gnt_wait) begin
          mem_gnt = 1'b1; given = 1'b1; since = 0;
          if (rv_lag == 0) mem_rvalid = 1'b1;
        end
      end else if (mem_req) begin
        r_req++;
      end else if (given) begin
        since++;
        if (since == rv_lag) mem_rvalid = 1'b1;
      end
      @(negedge clk);
      if (stall) r_stall++;
      if (stall && !mem_req && given) r_wait++;
      if (misaligned) r_mis++;
      if (done) begin
        r_done = 1'b1; r_err = bus_err; r_ld = load_data; fin = 1'b1;
      end
      if (r_mis >= 3) fin = 1'b1;
      @(posedge clk); #1;
    end
    if (!fin) check("access_budget", 32'h0, 32'h1);
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0;
    store_data = 32'h0; Load_type = 3'b000; Store_type = 2'b00;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_flags", {30'h0, misaligned, bus_err}, 32'h0);
    check("rst_bus", {28'h0, mem_be} | mem_addr | mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // SW 0x100, gnt on the second REQ cycle
    do_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 2'b00, 1, 99, 32'h0);
    check("sw_be", {28'h0, r_be}, 32'hF);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_addr", r_addr, 32'h100);
    check("sw_we", {31'h0, r_we}, 32'h1);
    check("sw_stall", r_stall, 3);
    check("sw_done", {30'h0, r_done, r_err}, 32'h2);

    // LB 0x103 with one WAIT cycle
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 3'b010, 2'b00, 0, 1, 32'h80112233);
    check("lb_data", r_ld, 32'hFFFFFF80);
    check("lb_addr", r_addr, 32'h100);
    check("lb_be_we", {27'h0, r_we, r_be}, 32'h0F);
    check("lb_wait", r_wait, 1);

    // LHU 0x102, gnt and rvalid together
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b011, 2'b00, 0, 0, 32'hBEEF1234);
    check("lhu_data", r_ld, 32'h0000BEEF);
    check("lhu_wait", r_wait, 0);
    check("lhu_stall", r_stall, 2);

    // SB 0x201
    do_access(1'b0, 1'b1, 32'h201, 32'h000000AB, 3'b000, 2'b10, 0, 99, 32'h0);
    check("sb_be", {28'h0, r_be}, 32'h2);
    check("sb_wdata", r_wdata, 32'hABABABAB);
    check("sb_addr", r_addr, 32'h200);

    // SH 0x101 is rejected without bus activity
    do_access(1'b0, 1'b1, 32'h101, 32'h00001234, 3'b000, 2'b01, 0, 99, 32'h0);
    check("sh_mis_pulse", {31'h0, r_mis > 0}, 32'h1);
    check("sh_mis_req", r_req, 0);
    check("sh_mis_stall", r_stall, 0);
    check("sh_mis_done", {31'h0, r_done}, 32'h0);
    check("sh_mis_ld_hold", load_data, 32'h0000BEEF);

    // LW with gnt never given
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 3'b000, 2'b00, 1000, 0, 32'h55555555);
    check("to_err_done", {30'h0, r_done, r_err}, 32'h3);
    check("to_load_data", r_ld, 32'h0);
    check("to_req_cycles", r_req, 64);
    check("to_stall", r_stall, 65);

    // Extra lanes: SH upper half, LH sign, LBU zero-extend
    do_access(1'b0, 1'b1, 32'h102, 32'hFFFF1234, 3'b000, 2'b01, 0, 99, 32'h0);
    check("sh_be", {28'h0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'h12341234);
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 2'b00, 2, 3, 32'h80017FFF);
    check("lh_data", r_ld, 32'hFFFF8001);
    check("lh_wait", r_wait, 3);
    do_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b111, 2'b00, 0, 0, 32'h0000F000);
    check("lbu_data", r_ld, 32'h000000F0);

    // Reset while waiting for rvalid; the late rvalid must be ignored
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h400; Load_type = 3'b000;
    @(negedge clk);
    check("rw_idle_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(negedge clk);
    check("rw_req", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rw_wait", {30'h0, stall, mem_req}, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    check("rw_after_rst", {29'h0, mem_req, stall, done}, 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rw_late_done", {31'h0, done}, 32'h0);
    check("rw_late_ld", load_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
